com8_report_tx: RTL and testbench

//  Transmit side of the com8 UART register link (8N1, 12 MHz CLK, 115200 baud).

---
 rtl/com8_report_tx.sv | 231 +++++++++++++++++++++++
 tb/tb_com8_report_tx.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/com8_report_tx.sv
// -----------------------------------------------------------------------------
// com8_report_tx
//   Transmit half of the com8 UART register link (8N1). Watches eight byte
//   registers and, whenever one of them differs from the last value reported
//   (or a dump has been requested), sends the ASCII report "R<i><H><L>\n",
//   where <i> is the register index and <H><L> is the value in uppercase hex.
//
// Ports
//   CLK          in   1  system clock (12 MHz); sole clock
//   RST          in   1  synchronous, active-high reset
//   DATA0..DATA7 in   8  watched register values, CLK domain
//   DUMP         in   1  one-cycle pulse: report all eight registers
//   TX           out  1  UART serial output, idle high, registered
//   BUSY         out  1  high while a report message is being sent
// -----------------------------------------------------------------------------
module com8_report_tx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DATA0,
  input  logic [7:0] DATA1,
  input  logic [7:0] DATA2,
  input  logic [7:0] DATA3,
  input  logic [7:0] DATA4,
  input  logic [7:0] DATA5,
  input  logic [7:0] DATA6,
  input  logic [7:0] DATA7,
  input  logic       DUMP,
  output logic       TX,
  output logic       BUSY
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txStateT;

  txStateT          stateQ, stateD;
  logic [CNT_W-1:0] clkCntQ, clkCntD;
  logic [2:0]       bitIdxQ, bitIdxD;
  logic [2:0]       charIdxQ, charIdxD;
  logic [2:0]       chanQ, chanD;
  logic [7:0]       valQ, valD;
  logic [7:0]       shadowQ [8];
  logic [7:0]       shadowD [8];
  logic [7:0]       forceQ, forceD;
  logic             txQ, txD;
  logic             busyQ, busyD;

  logic [7:0]       dataArr [8];
  logic [7:0]       pend;
  logic [2:0]       selIdx;
  logic [7:0]       curByte;
  logic [2:0]       nextBit;

  assign dataArr[0] = DATA0;
  assign dataArr[1] = DATA1;
  assign dataArr[2] = DATA2;
  assign dataArr[3] = DATA3;
  assign dataArr[4] = DATA4;
  assign dataArr[5] = DATA5;
  assign dataArr[6] = DATA6;
  assign dataArr[7] = DATA7;

  assign TX      = txQ;
  assign BUSY    = busyQ;
  assign nextBit = bitIdxQ + 3'd1;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hexChar(input logic [3:0] d);
    if (d <= 4'd9) begin
      return 8'h30 + {4'h0, d};
    end
    return 8'h37 + {4'h0, d};
  endfunction

  // A register needs a report when it has drifted from what the host last saw,
  // or when a dump has flagged it. A value that wanders away and back before
  // capture therefore never produces a report.
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      pend[n] = (dataArr[n] != shadowQ[n]) | forceQ[n];
    end
  end

  // Fixed priority: scan downwards so the lowest pending index wins.
  always_comb begin
    selIdx = 3'd0;
    for (int n = 7; n >= 0; n--) begin
      if (pend[n]) begin
        selIdx = 3'(n);
      end
    end
  end

  // Character currently on the wire, built from the value captured at the
  // start of the message so later register changes cannot corrupt it.
  always_comb begin
    case (charIdxQ)
      3'd0:    curByte = 8'h52;
      3'd1:    curByte = 8'h30 + {5'b0, chanQ};
      3'd2:    curByte = hexChar(valQ[7:4]);
      3'd3:    curByte = hexChar(valQ[3:0]);
      default: curByte = 8'h0A;
    endcase
  end

  // Framing FSM. TX is computed one cycle ahead and registered, so every
  // transition here determines the line level of the following cycle. The
  // last cycle of each bit loads the first level of the next bit, which keeps
  // every bit exactly CLKS_PER_BIT cycles and leaves no gap between bytes.
  always_comb begin
    stateD   = stateQ;
    clkCntD  = clkCntQ;
    bitIdxD  = bitIdxQ;
    charIdxD = charIdxQ;
    chanD    = chanQ;
    valD     = valQ;
    forceD   = forceQ;
    txD      = txQ;
    busyD    = busyQ;
    for (int n = 0; n < 8; n++) begin
      shadowD[n] = shadowQ[n];
    end

    case (stateQ)
      IDLE: begin
        if (|pend) begin
          valD            = dataArr[selIdx];
          chanD           = selIdx;
          shadowD[selIdx] = dataArr[selIdx];
          forceD[selIdx]  = 1'b0;
          charIdxD        = 3'd0;
          clkCntD         = '0;
          txD             = 1'b0;
          busyD           = 1'b1;
          stateD          = START;
        end
      end
      START: begin
        if (clkCntQ == LAST_CLK) begin
          clkCntD = '0;
          bitIdxD = 3'd0;
          txD     = curByte[0];
          stateD  = DATA;
        end else begin
          clkCntD = clkCntQ + 1'b1;
        end
      end
      DATA: begin
        if (clkCntQ == LAST_CLK) begin
          clkCntD = '0;
          if (bitIdxQ == 3'd7) begin
            txD    = 1'b1;
            stateD = STOP;
          end else begin
            bitIdxD = nextBit;
            txD     = curByte[nextBit];
          end
        end else begin
          clkCntD = clkCntQ + 1'b1;
        end
      end
      STOP: begin
        if (clkCntQ == LAST_CLK) begin
          clkCntD = '0;
          if (charIdxQ == 3'd4) begin
            busyD  = 1'b0;
            stateD = IDLE;
          end else begin
            charIdxD = charIdxQ + 3'd1;
            txD      = 1'b0;
            stateD   = START;
          end
        end else begin
          clkCntD = clkCntQ + 1'b1;
        end
      end
      default: begin
        txD    = 1'b1;
        busyD  = 1'b0;
        stateD = IDLE;
      end
    endcase

    // A dump in the capture cycle must keep the captured register flagged,
    // so it overrides the clear above.
    if (DUMP) begin
      forceD = 8'hFF;
    end
  end

  // State register. Reset abandons any message in flight and clears the
  // shadows, so every nonzero register is reported again afterwards.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stateQ   <= IDLE;
      clkCntQ  <= '0;
      bitIdxQ  <= 3'd0;
      charIdxQ <= 3'd0;
      chanQ    <= 3'd0;
      valQ     <= 8'h00;
      forceQ   <= 8'h00;
      txQ      <= 1'b1;
      busyQ    <= 1'b0;
      for (int n = 0; n < 8; n++) begin
        shadowQ[n] <= 8'h00;
      end
    end else begin
      stateQ   <= stateD;
      clkCntQ  <= clkCntD;
      bitIdxQ  <= bitIdxD;
      charIdxQ <= charIdxD;
      chanQ    <= chanD;
      valQ     <= valD;
      forceQ   <= forceD;
      txQ      <= txD;
      busyQ    <= busyD;
      for (int n = 0; n < 8; n++) begin
        shadowQ[n] <= shadowD[n];
      end
    end
  end

endmodule

// File: tb/tb_com8_report_tx.sv
// -----------------------------------------------------------------------------
// tb_com8_report_tx
//   Directed bench for com8_report_tx. Each scenario task drives its stimulus
//   and compares the decoded serial reports, bit timing, BUSY envelope and
//   idle behaviour against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_com8_report_tx;

  localparam int CPB        = 104;
  localparam int MSG_CYCLES = 50 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       dump;
  logic [7:0] dataIn [8];
  logic       tx;
  logic       busy;

  int total = 0;
  int bad   = 0;

  com8_report_tx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK  (clk),
    .RST  (rst),
    .DATA0(dataIn[0]),
    .DATA1(dataIn[1]),
    .DATA2(dataIn[2]),
    .DATA3(dataIn[3]),
    .DATA4(dataIn[4]),
    .DATA5(dataIn[5]),
    .DATA6(dataIn[6]),
    .DATA7(dataIn[7]),
    .DUMP (dump),
    .TX   (tx),
    .BUSY (busy)
  );

  // 10 time-unit clock period.
  always #5 clk = ~clk;

  // Captures one whole message from the line: waits (bounded) for the start
  // bit, records TX for 50 bit times, then decodes the five characters from
  // mid-bit samples. shapeErr counts cycles where the line disagrees with the
  // mid-bit level of its bit slot (or with start=0 / stop=1), which exposes
  // wrong bit widths. The cycle right after the message is also sampled.
  task automatic recvMsg(input int maxWait, output bit timedOut, output int waited,
                         output logic [39:0] rx, output int shapeErr, output int busyErr,
                         output logic idleTx, output logic idleBusy);
    logic       wave [MSG_CYCLES];
    logic [7:0] rxByte;
    logic       mid;
    logic       expBit;
    timedOut = 1'b0;
    waited   = 0;
    rx       = '0;
    shapeErr = 0;
    busyErr  = 0;
    idleTx   = 1'bx;
    idleBusy = 1'bx;
    @(negedge clk);
    while (tx !== 1'b0) begin
      if (waited >= maxWait) begin
        timedOut = 1'b1;
        return;
      end
      waited++;
      @(negedge clk);
    end
    for (int j = 0; j < MSG_CYCLES; j++) begin
      if (j > 0) @(negedge clk);
      wave[j] = tx;
      if (busy !== 1'b1) busyErr++;
    end
    @(negedge clk);
    idleTx   = tx;
    idleBusy = busy;
    for (int b = 0; b < 5; b++) begin
      rxByte = 8'h00;
      for (int p = 0; p < 10; p++) begin
        mid = wave[(b * 10 + p) * CPB + CPB / 2];
        if (p == 0) expBit = 1'b0;
        else if (p == 9) expBit = 1'b1;
        else begin
          expBit = mid;
          rxByte[p - 1] = mid;
        end
        for (int c = 0; c < CPB; c++) begin
          if (wave[(b * 10 + p) * CPB + c] !== expBit) shapeErr++;
        end
      end
      rx = {rx[31:0], rxByte};
    end
  endtask

  // Counts cycles over a window where the line is not idle (TX=1, BUSY=0).
  task automatic idleWatch(input int n, output int badCycles);
    badCycles = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) badCycles++;
    end
  endtask

  task automatic test_reset();
    int badCycles;
    rst  = 1'b1;
    dump = 1'b0;
    for (int n = 0; n < 8; n++) dataIn[n] = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if (tx !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_tx: got %b want 1", tx);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_busy: got %b want 0", busy);
    end
    rst = 1'b0;
    idleWatch(3000, badCycles);
    total++;
    if (badCycles !== 0) begin
      bad++;
      $display("[TB] FAIL reset_idle: %0d non-idle cycles, want 0", badCycles);
    end
  endtask

  task automatic test_single();
    bit          to;
    int          waited, shapeErr, busyErr, badCycles;
    logic [39:0] rx;
    logic        idleTx, idleBusy;
    @(negedge clk);
    dataIn[0] = 8'd155;
    recvMsg(10, to, waited, rx, shapeErr, busyErr, idleTx, idleBusy);
    total++;
    if (to || rx !== "R09B\n") begin
      bad++;
      $display("[TB] FAIL single_msg: got %h (timeout=%0d) want %h", rx, to, "R09B\n");
    end
    total++;
    if (waited !== 0) begin
      bad++;
      $display("[TB] FAIL single_latency: start after %0d cycles, want 0", waited);
    end
    total++;
    if (shapeErr !== 0) begin
      bad++;
      $display("[TB] FAIL single_bit_width: %0d bad line cycles, want 0", shapeErr);
    end
    total++;
    if (busyErr !== 0) begin
      bad++;
      $display("[TB] FAIL single_busy: BUSY low in %0d of %0d cycles, want 0", busyErr, MSG_CYCLES);
    end
    total++;
    if (idleTx !== 1'b1 || idleBusy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_end: TX=%b BUSY=%b want TX=1 BUSY=0", idleTx, idleBusy);
    end
    idleWatch(200, badCycles);
    total++;
    if (badCycles !== 0) begin
      bad++;
      $display("[TB] FAIL single_after: %0d non-idle cycles, want 0", badCycles);
    end
  endtask

  task automatic test_dump();
    bit          to;
    int          waited, shapeErr, busyErr, badCycles;
    logic [39:0] rx;
    logic        idleTx, idleBusy;
    logic [39:0] expMsg [8];
    expMsg[0] = "R09B\n";
    expMsg[1] = "R100\n";
    expMsg[2] = "R200\n";
    expMsg[3] = "R300\n";
    expMsg[4] = "R400\n";
    expMsg[5] = "R500\n";
    expMsg[6] = "R600\n";
    expMsg[7] = "R700\n";
    @(negedge clk);
    dump = 1'b1;
    @(negedge clk);
    dump = 1'b0;
    for (int i = 0; i < 8; i++) begin
      recvMsg(10, to, waited, rx, shapeErr, busyErr, idleTx, idleBusy);
      total++;
      if (to || rx !== expMsg[i] || waited !== 0) begin
        bad++;
        $display("[TB] FAIL dump_msg%0d: got %h gap=%0d timeout=%0d want %h gap=0",
                 i, rx, waited, to, expMsg[i]);
      end
      total++;
      if (shapeErr !== 0 || busyErr !== 0 || idleTx !== 1'b1 || idleBusy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL dump_frame%0d: shape=%0d busyErr=%0d end TX=%b BUSY=%b want 0 0 1 0",
                 i, shapeErr, busyErr, idleTx, idleBusy);
      end
    end
    idleWatch(300, badCycles);
    total++;
    if (badCycles !== 0) begin
      bad++;
      $display("[TB] FAIL dump_after: %0d non-idle cycles, want 0", badCycles);
    end
  endtask

  task automatic test_back_to_back();
    bit          to;
    int          waited, shapeErr, busyErr;
    logic [39:0] rx;
    logic        idleTx, idleBusy;
    @(negedge clk);
    dataIn[5] = 8'hAA;
    dataIn[2] = 8'h01;
    recvMsg(10, to, waited, rx, shapeErr, busyErr, idleTx, idleBusy);
    total++;
    if (to || rx !== "R201\n") begin
      bad++;
      $display("[TB] FAIL pair_first: got %h (timeout=%0d) want %h", rx, to, "R201\n");
    end
    total++;
    if (shapeErr !== 0 || busyErr !== 0 || idleTx !== 1'b1 || idleBusy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL pair_first_frame: shape=%0d busyErr=%0d end TX=%b BUSY=%b want 0 0 1 0",
               shapeErr, busyErr, idleTx, idleBusy);
    end
    recvMsg(10, to, waited, rx, shapeErr, busyErr, idleTx, idleBusy);
    total++;
    if (to || rx !== "R5AA\n") begin
      bad++;
      $display("[TB] FAIL pair_second: got %h (timeout=%0d) want %h", rx, to, "R5AA\n");
    end
    total++;
    if (waited !== 0) begin
      bad++;
      $display("[TB] FAIL pair_gap: extra idle cycles %0d, want 0", waited);
    end
    total++;
    if (shapeErr !== 0 || busyErr !== 0 || idleTx !== 1'b1 || idleBusy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL pair_second_frame: shape=%0d busyErr=%0d end TX=%b BUSY=%b want 0 0 1 0",
               shapeErr, busyErr, idleTx, idleBusy);
    end
  endtask

  task automatic test_coalesce();
    bit          to;
    int          waited, shapeErr, busyErr, badCycles;
    logic [39:0] rx;
    logic        idleTx, idleBusy;
    @(negedge clk);
    dataIn[0] = 8'h11;
    fork
      recvMsg(10, to, waited, rx, shapeErr, busyErr, idleTx, idleBusy);
      begin
        repeat (600) @(negedge clk);
        dataIn[3] = 8'h10;
        repeat (200) @(negedge clk);
        dataIn[3] = 8'h20;
        dataIn[4] = 8'h55;
        repeat (200) @(negedge clk);
        dataIn[3] = 8'h30;
        dataIn[4] = 8'h00;
      end
    join
    total++;
    if (to || rx !== "R011\n") begin
      bad++;
      $display("[TB] FAIL coalesce_inflight: got %h (timeout=%0d) want %h", rx, to, "R011\n");
    end
    total++;
    if (shapeErr !== 0 || busyErr !== 0) begin
      bad++;
      $display("[TB] FAIL coalesce_inflight_frame: shape=%0d busyErr=%0d want 0 0", shapeErr, busyErr);
    end
    recvMsg(10, to, waited, rx, shapeErr, busyErr, idleTx, idleBusy);
    total++;
    if (to || rx !== "R330\n" || waited !== 0) begin
      bad++;
      $display("[TB] FAIL coalesce_latest: got %h gap=%0d timeout=%0d want %h gap=0",
               rx, waited, to, "R330\n");
    end
    idleWatch(400, badCycles);
    total++;
    if (badCycles !== 0) begin
      bad++;
      $display("[TB] FAIL coalesce_no_ch4: %0d non-idle cycles, want 0", badCycles);
    end
  endtask

  task automatic test_reset_mid();
    bit          to;
    int          waited, shapeErr, busyErr, badCycles;
    logic [39:0] rx;
    logic        idleTx, idleBusy;
    bit          started;
    @(negedge clk);
    dataIn[0] = 8'h22;
    started = 1'b0;
    for (int i = 0; i < 20 && !started; i++) begin
      @(negedge clk);
      if (tx === 1'b0) started = 1'b1;
    end
    total++;
    if (!started) begin
      bad++;
      $display("[TB] FAIL midrst_start: TX=%b after 20 cycles, want 0", tx);
    end
    // Cycle 2546 of the message sits inside data bit 3 of byte 2.
    repeat (2546) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midrst_busy_before: got %b want 1", busy);
    end
    rst = 1'b1;
    for (int n = 0; n < 8; n++) dataIn[n] = 8'h00;
    dataIn[6] = 8'h7F;
    @(negedge clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_abort: TX=%b BUSY=%b want TX=1 BUSY=0", tx, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    recvMsg(10, to, waited, rx, shapeErr, busyErr, idleTx, idleBusy);
    total++;
    if (to || rx !== "R67F\n") begin
      bad++;
      $display("[TB] FAIL midrst_fresh: got %h (timeout=%0d) want %h", rx, to, "R67F\n");
    end
    total++;
    if (shapeErr !== 0 || busyErr !== 0 || idleTx !== 1'b1 || idleBusy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_frame: shape=%0d busyErr=%0d end TX=%b BUSY=%b want 0 0 1 0",
               shapeErr, busyErr, idleTx, idleBusy);
    end
    idleWatch(300, badCycles);
    total++;
    if (badCycles !== 0) begin
      bad++;
      $display("[TB] FAIL midrst_after: %0d non-idle cycles, want 0", badCycles);
    end
  endtask

  initial begin
    $display("[TB] com8_report_tx directed tests start");
    test_reset();
    test_single();
    test_dump();
    test_back_to_back();
    test_coalesce();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
